// File: rtl/qpsk_pkg.sv
// Shared constants for the QPSK transmit/receive pair: window geometry,
// symbol width and the offset-binary zero level.
package qpsk_pkg;

    localparam int DEF_SPS_LOG2 = 8;
    localparam int DEF_SAMPLE_W = 8;
    localparam int DEF_MIN_PEAK = 192;

    localparam int SPS_N      = 1 << DEF_SPS_LOG2;
    localparam int SPS_Q      = SPS_N / 4;
    localparam int SPS_HALF_Q = SPS_Q / 2;

    localparam int SYM_W      = 2;
    localparam int ZERO_LEVEL = 1 << (DEF_SAMPLE_W - 1);

endpackage

// File: rtl/qpsk_demodulator_piso.sv
// 2-bit parallel-in, serial-out, MSB first; mirror of the transmit SIPO.
module piso
    import qpsk_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SYM_W-1:0] din,
    output logic             bit_out,
    output logic             bit_valid
);

    logic lo_bit;
    logic pending;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            lo_bit    <= 1'b0;
            pending   <= 1'b0;
        end else if (load) begin
            bit_out   <= din[1];
            bit_valid <= 1'b1;
            lo_bit    <= din[0];
            pending   <= 1'b1;
        end else if (pending) begin
            bit_out   <= lo_bit;
            bit_valid <= 1'b1;
            pending   <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/qpsk_demodulator.sv
// QPSK receiver: per-window peak search, peak position -> 2-bit phase symbol,
// parallel and MSB-first serial output.
module qpsk_demodulator
    import qpsk_pkg::*;
#(
    parameter int SPS_LOG2 = DEF_SPS_LOG2,
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int MIN_PEAK = DEF_MIN_PEAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [SYM_W-1:0]    sym_out,
    output logic                sym_valid,
    output logic                sym_err,
    output logic                bit_out,
    output logic                bit_valid
);

    localparam logic [SPS_LOG2-1:0] LAST_IDX   = '1;
    localparam logic [SPS_LOG2-1:0] Q_L        = SPS_LOG2'(1) << (SPS_LOG2 - 2);
    localparam logic [SPS_LOG2-1:0] HALF_Q_L   = Q_L >> 1;
    localparam logic [SAMPLE_W-1:0] MIN_PEAK_L = SAMPLE_W'(MIN_PEAK);

    logic [SPS_LOG2-1:0] idx;
    logic [SAMPLE_W-1:0] peak;
    logic [SPS_LOG2-1:0] p;
    logic                win_end;
    logic [SPS_LOG2-1:0] off;
    logic [SPS_LOG2-1:0] rnd;
    logic [SYM_W-1:0]    sym;

    // win_end flags that the last sample is already folded into peak/p,
    // so decode reads settled tracker state on the following edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx     <= '0;
            peak    <= '0;
            p       <= '0;
            win_end <= 1'b0;
        end else begin
            win_end <= sample_valid && (idx == LAST_IDX);
            if (sample_valid) begin
                idx <= idx + SPS_LOG2'(1);
                if ((idx == '0) || (sample_in > peak)) begin
                    peak <= sample_in;
                    p    <= idx;
                end
            end
        end
    end

    // Modular wrap in SPS_LOG2 bits makes the top two bits the quadrant.
    always_comb begin
        off = Q_L - p;
        rnd = off + HALF_Q_L;
        sym = SYM_W'(rnd >> (SPS_LOG2 - 2));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sym_out   <= '0;
            sym_valid <= 1'b0;
            sym_err   <= 1'b0;
        end else begin
            sym_valid <= win_end;
            if (win_end) begin
                sym_out <= sym;
                sym_err <= (peak < MIN_PEAK_L);
            end
        end
    end

    piso u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (win_end),
        .din       (sym),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Directed bench for qpsk_demodulator: triangle-shaped carrier windows with
// hand-derived peak positions and symbols.
module tb_qpsk_demodulator;
    import qpsk_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic [1:0] sym_out;
    logic       sym_valid;
    logic       sym_err;
    logic       bit_out;
    logic       bit_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int sv_count = 0;

    qpsk_demodulator #(.SPS_LOG2(8), .SAMPLE_W(8), .MIN_PEAK(192)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_out      (sym_out),
        .sym_valid    (sym_valid),
        .sym_err      (sym_err),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst && sym_valid) sv_count++;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sine-like triangle: max at k=64 (ZERO+amp), min at k=192.
    function automatic logic [7:0] wave(input int k, input int amp);
        int s;
        if (k < 64)       s = k * amp / 64;
        else if (k < 192) s = amp - (k - 64) * amp / 64;
        else              s = -amp + (k - 192) * amp / 64;
        return 8'(ZERO_LEVEL + s);
    endfunction

    task automatic run_window(input string tag, input int shift, input int amp,
                              input bit sparse, input bit plateau,
                              input int exp_sym, input int exp_err);
        int base;
        int lat;
        logic [7:0] v;
        logic [1:0] es;
        es   = 2'(exp_sym);
        base = sv_count;
        for (int n = 0; n < SPS_N; n++) begin
            v = wave((n + shift) % SPS_N, amp);
            if (plateau && n >= 62 && n <= 66) v = 8'd255;
            @(negedge clk);
            sample_in    = v;
            sample_valid = 1'b1;
            if (sparse && n < SPS_N - 1) begin
                @(negedge clk);
                sample_valid = 1'b0;
                sample_in    = 8'hFF;
            end
        end
        lat = 0;
        for (int c = 1; c <= 8 && lat == 0; c++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            sample_in    = '0;
            if (sym_valid) lat = c;
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, lat, 2);
            check({tag, "_sym"}, int'(sym_out), exp_sym);
            check({tag, "_err"}, int'(sym_err), exp_err);
            check({tag, "_bit1"}, int'(bit_out), int'(es[1]));
            check({tag, "_bv1"}, int'(bit_valid), 1);
            @(negedge clk);
            check({tag, "_svpulse"}, int'(sym_valid), 0);
            check({tag, "_bit0"}, int'(bit_out), int'(es[0]));
            check({tag, "_bv0"}, int'(bit_valid), 1);
            @(negedge clk);
            check({tag, "_bvend"}, int'(bit_valid), 0);
            check({tag, "_hold"}, int'(sym_out), exp_sym);
        end
        check({tag, "_ndecode"}, sv_count - base, 1);
    endtask

    initial begin
        int base;
        rst          = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        @(negedge clk);
        check("rst_sym_out", int'(sym_out), 0);
        check("rst_sym_valid", int'(sym_valid), 0);
        check("rst_sym_err", int'(sym_err), 0);
        check("rst_bit_out", int'(bit_out), 0);
        check("rst_bit_valid", int'(bit_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_window("sym0",    0, 127, 1'b0, 1'b0, 0, 0);
        run_window("sym1",   64, 127, 1'b0, 1'b0, 1, 0);
        run_window("sym2",  128, 127, 1'b0, 1'b0, 2, 0);
        run_window("sym3",  192, 127, 1'b0, 1'b0, 3, 0);
        run_window("plateau", 0, 127, 1'b0, 1'b1, 0, 0);
        run_window("lowamp", 128, 32, 1'b0, 1'b0, 2, 1);
        run_window("sparse",  64, 127, 1'b1, 1'b0, 1, 0);

        // Partial window of 100 samples, then reset
        base = sv_count;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            sample_in    = wave(n, 127);
            sample_valid = 1'b1;
        end
        @(negedge clk);
        sample_valid = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        check("midrst_sym_out", int'(sym_out), 0);
        check("midrst_bit_valid", int'(bit_valid), 0);
        check("midrst_sym_valid", int'(sym_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_nodecode", sv_count - base, 0);
        run_window("postrst", 192, 127, 1'b0, 1'b0, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qpsk_demodulator.md
# qpsk_demodulator

Receive-side counterpart of the QPSK modulator. It consumes the sampled carrier one amplitude per valid strobe and finds the peak-sample position in each fixed-length symbol window. It converts that position back to the transmitted 2-bit phase symbol. The symbol is presented in parallel and also serialised MSB-first, restoring the bit stream that fed the modulator's SIPO.

## Interface
Parameters:
- SPS_LOG2, default 8: log2 of samples per symbol, N = 2^SPS_LOG2; must be >= 2.
- SAMPLE_W, default 8: sample width, unsigned offset-binary, with 2^(SAMPLE_W-1) as zero level.
- MIN_PEAK, default 192: minimum window peak for a trusted symbol.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- sample_in  input  SAMPLE_W  carrier amplitude.
- sample_valid  input  1  sample_in is accepted on this edge.
- sym_out  output  2  last decoded symbol, held until the next decode.
- sym_valid  output  1  one-cycle pulse when sym_out updates.
- sym_err  output  1  valid with sym_valid; set when the window peak is below MIN_PEAK.
- bit_out  output  1  serial symbol bit.
- bit_valid  output  1  bit_out is meaningful.

## Operation
- Sample counter idx, SPS_LOG2 bits:
  - Counts accepted samples only.
  - Wraps from N-1 to 0.
  - The first accepted sample after reset is index 0 of a window.
- Peak tracker holds the maximum value and its index p:
  - At idx 0 it loads unconditionally.
  - Afterwards it updates only on a strictly greater value, so on ties the first occurrence wins.
- Window end is the accepted sample with idx == N-1. On the next edge:
  - Let Q = N/4.
  - off = (Q - p) mod N, computed with SPS_LOG2-bit wrap arithmetic.
  - sym = ((off + Q/2) >> (SPS_LOG2-2)) mod 4. This rounds to the nearest quarter and absorbs flat-top LUT plateaus.
  - sym_out <= sym; sym_err <= (peak < MIN_PEAK); sym_valid pulses.
- The tracker restarts on the next accepted sample (idx 0). The final sample of a window is included in that window's peak search.
- Serialiser loads sym on the decode edge:
  - bit_out = sym[1] with bit_valid = 1 in the sym_valid cycle.
  - bit_out = sym[0] with bit_valid = 1 in the following cycle.
  - bit_valid = 0 otherwise.
- Gaps in sample_valid freeze idx and the tracker. Decode and serialisation proceed regardless of sample_valid.
- Symbol-to-bit mapping is direct binary (k -> bits k), matching the transmit side.

## Timing
- Reset values (asynchronous, while rst = 0): idx 0, peak 0, p 0, sym_out 0, sym_valid 0, sym_err 0, bit_out 0, bit_valid 0.
- Latency: sym_valid is high 1 cycle after the edge accepting sample N-1. The last bit is out 2 cycles after that edge.
- Minimum spacing between decodes is N >= 4 cycles, so the 2-cycle serialiser can never be overrun.
- Reset mid-window discards the partial window. The next accepted sample after release is index 0. No sym_valid is generated for the discarded window.
- sample_valid at window end coinciding with a serialiser bit: both proceed independently.

## Structure
- Shared package qpsk_pkg holds:
  - SPS_LOG2 default
  - derived N, Q and half-Q constants
  - SYM_W = 2
  - zero-level constant
- Sub-module piso (2-bit parallel-in, serial-out with valid, MSB first) is the mirror of the transmit SIPO and is instantiated once.
- The counter, peak tracker and decode arithmetic live in the top.

## Test plan
- Symbol 0: a 256-sample sine (LUT index n) -> peak at p = 64, sym_out = 0, sym_valid at cycle 257, bits 0,0.
- Symbols 1, 2, 3: LUT indices n+64, n+128, n+192 -> p = 0, 192, 128 -> sym_out 1, 2, 3. Bit pairs are 0,1 / 1,0 / 1,1.
- Plateau tie: samples 62..66 all 255, with symbol 0 otherwise -> p = 62 -> off 2 -> sym_out 0, sym_err 0.
- Low amplitude: symbol-2 sine scaled so the peak = 160 -> sym_out 2, sym_err 1.
- Sparse valid: same symbol-1 window with sample_valid toggling every other cycle -> identical result, sym_valid 1 cycle after the 256th accepted sample.
- Reset mid-window: drop rst at sample 100, release, then send a full symbol-3 window -> no decode for the partial window, then sym_out 3 with bits 1,1.
